// File: rtl/gather_vc_allocator_pkg.sv
// Shared definitions for the output-port VC allocator and the input gather controllers.
package gather_vc_allocator_pkg;

  localparam int NI = 5;
  localparam int CN = 4;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2
  } flit_type_e;

  // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
  function automatic logic [CN-1:0] onehot_lowest(input logic [CN-1:0] vec);
    return vec & (~vec + CN'(1));
  endfunction

endpackage

// File: rtl/gather_vc_allocator_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap, reports the slot after the winner.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);

  // Priority search starting at ptr; the first requester found wins.
  always_comb begin
    int   idx_s;
    logic hit_s;
    logic found_s;
    gnt     = '0;
    nxt_ptr = ptr;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s   = int'(ptr) + k;
      idx_s   = (idx_s >= N) ? (idx_s - N) : idx_s;
      hit_s   = req[idx_s] & ~found_s;
      gnt[idx_s] = gnt[idx_s] | hit_s;
      found_s = found_s | hit_s;
      nxt_ptr = hit_s ? ((idx_s == N - 1) ? PW'(0) : PW'(idx_s + 1)) : nxt_ptr;
    end
  end

endmodule

// File: rtl/gather_vc_allocator.sv
// Separable output-VC allocator: lowest free candidate per input, then round-robin per VC.
module gather_vc_allocator #(
  parameter int NI = gather_vc_allocator_pkg::NI,
  parameter int CN = gather_vc_allocator_pkg::CN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NI*CN-1:0] req_vc,
  input  logic [CN-1:0]    vc_release,
  output logic [NI-1:0]    vc_granted,
  output logic [NI*CN-1:0] sel_out_vc,
  output logic [CN-1:0]    vc_busy
);
  import gather_vc_allocator_pkg::*;

  localparam int PW = (NI > 1) ? $clog2(NI) : 1;

  logic [CN-1:0] busy_r;
  logic [PW-1:0] ptr_r     [CN];
  logic [CN-1:0] pick_s    [NI];
  logic [NI-1:0] arb_req_s [CN];
  logic [NI-1:0] arb_gnt_s [CN];
  logic [PW-1:0] nxt_ptr_s [CN];

  // Stage 1: each input nominates its lowest-index candidate that is not already owned.
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      pick_s[i] = onehot_lowest(req_vc[i*CN +: CN] & ~busy_r);
    end
  end

  // Regroup nominations by VC for the per-VC arbiters.
  always_comb begin
    for (int v = 0; v < CN; v++) begin
      for (int i = 0; i < NI; i++) begin
        arb_req_s[v][i] = pick_s[i][v];
      end
    end
  end

  for (genvar v = 0; v < CN; v++) begin : g_vc_arb
    rr_arbiter #(.N(NI), .PW(PW)) u_rr_arbiter (
      .req     (arb_req_s[v]),
      .ptr     (ptr_r[v]),
      .gnt     (arb_gnt_s[v]),
      .nxt_ptr (nxt_ptr_s[v])
    );
  end

  // Grant outputs; stage 1 gives one nomination per input, so at most one VC per input.
  always_comb begin
    vc_granted = '0;
    sel_out_vc = '0;
    if (rst) begin
      vc_granted = '0;
      sel_out_vc = '0;
    end else begin
      for (int v = 0; v < CN; v++) begin
        for (int i = 0; i < NI; i++) begin
          vc_granted[i]        = vc_granted[i] | arb_gnt_s[v][i];
          sel_out_vc[i*CN + v] = arb_gnt_s[v][i];
        end
      end
    end
  end

  // Ownership and pointer update; a granted VC was free, so it cannot be released the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      for (int v = 0; v < CN; v++) begin
        ptr_r[v] <= PW'(0);
      end
    end else begin
      for (int v = 0; v < CN; v++) begin
        if (|arb_gnt_s[v]) begin
          busy_r[v] <= 1'b1;
          ptr_r[v]  <= nxt_ptr_s[v];
        end else if (vc_release[v]) begin
          busy_r[v] <= 1'b0;
        end else begin
          busy_r[v] <= busy_r[v];
        end
      end
    end
  end

  assign vc_busy = busy_r;

endmodule

// File: tb/tb_gather_vc_allocator.sv
// Directed and randomized checks of gather_vc_allocator against a queue-based reference model.
module tb_gather_vc_allocator;

  localparam int NI = 5;
  localparam int CN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI*CN-1:0] req_vc = '0;
  logic [CN-1:0]    vc_release = '0;
  logic [NI-1:0]    vc_granted;
  logic [NI*CN-1:0] sel_out_vc;
  logic [CN-1:0]    vc_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: ownership and next-favoured input per VC.
  bit m_busy [CN];
  int m_ptr  [CN];
  int m_win  [CN];
  logic [NI-1:0]    exp_gnt;
  logic [NI*CN-1:0] exp_sel;
  logic [NI-1:0]    obs_gnt;
  logic [NI*CN-1:0] obs_sel;

  gather_vc_allocator #(.NI(NI), .CN(CN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vc     (req_vc),
    .vc_release (vc_release),
    .vc_granted (vc_granted),
    .sel_out_vc (sel_out_vc),
    .vc_busy    (vc_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compute expected grants from the allocation rules using candidate lists.
  task automatic model_grants(input logic [NI*CN-1:0] req, input logic r);
    int choice [NI];
    int cands [$];
    exp_gnt = '0;
    exp_sel = '0;
    for (int v = 0; v < CN; v++) m_win[v] = -1;
    if (!r) begin
      for (int i = 0; i < NI; i++) begin
        choice[i] = -1;
        for (int v = CN - 1; v >= 0; v--)
          if (req[i*CN + v] && !m_busy[v]) choice[i] = v;
      end
      for (int v = 0; v < CN; v++) begin
        cands.delete();
        for (int k = 0; k < NI; k++)
          if (choice[(m_ptr[v] + k) % NI] == v) cands.push_back((m_ptr[v] + k) % NI);
        if (cands.size() > 0) begin
          m_win[v] = cands[0];
          exp_gnt[cands[0]] = 1'b1;
          exp_sel[cands[0]*CN + v] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge(input logic [CN-1:0] rel, input logic r);
    for (int v = 0; v < CN; v++) begin
      if (r) begin
        m_busy[v] = 1'b0;
        m_ptr[v]  = 0;
      end else if (m_win[v] >= 0) begin
        m_busy[v] = 1'b1;
        m_ptr[v]  = (m_win[v] + 1) % NI;
      end else if (rel[v]) begin
        m_busy[v] = 1'b0;
      end
    end
  endtask

  function automatic logic [CN-1:0] model_busy_vec();
    logic [CN-1:0] b;
    for (int v = 0; v < CN; v++) b[v] = m_busy[v];
    return b;
  endfunction

  // One cycle: drive, check combinational grants, clock, check registered busy.
  task automatic step(input logic [NI*CN-1:0] req, input logic [CN-1:0] rel, input logic r, input string tag);
    @(negedge clk);
    req_vc = req;
    vc_release = rel;
    rst = r;
    #1;
    model_grants(req, r);
    obs_gnt = vc_granted;
    obs_sel = sel_out_vc;
    check(32'(obs_gnt), 32'(exp_gnt), {tag, "_gnt"});
    check(32'(obs_sel), 32'(exp_sel), {tag, "_sel"});
    @(posedge clk);
    model_edge(rel, r);
    #1;
    check(32'(vc_busy), 32'(model_busy_vec()), {tag, "_busy"});
  endtask

  initial begin
    for (int v = 0; v < CN; v++) begin
      m_busy[v] = 1'b0;
      m_ptr[v]  = 0;
      m_win[v]  = -1;
    end

    // Reset with every input requesting everything.
    step({(NI*CN){1'b1}}, 4'b0000, 1'b1, "rst_hold");
    check(32'(obs_gnt), 32'd0, "rst_gnt_zero");
    check(32'(obs_sel), 32'd0, "rst_sel_zero");
    check(32'(vc_busy), 32'd0, "rst_busy_zero");
    step({(NI*CN){1'b1}}, 4'b0000, 1'b0, "first_grant");
    check(32'(obs_gnt), 32'h01, "first_grant_in0");
    check(32'(obs_sel), 32'h00001, "first_grant_vc0");

    // Single request from input 2.
    step(20'h00000, 4'b0000, 1'b1, "rst2");
    step(20'h00600, 4'b0000, 1'b0, "single");
    check(32'(obs_gnt), 32'h04, "single_gnt");
    check(32'(obs_sel), 32'h00200, "single_sel");
    check(32'(vc_busy), 32'h2, "single_busy");

    // Round-robin between inputs 0 and 3 on VC0.
    step(20'h00000, 4'b0010, 1'b0, "rr_clear");
    step(20'h01001, 4'b0000, 1'b0, "rr_a");
    check(32'(obs_gnt), 32'h01, "rr_first_in0");
    step(20'h01001, 4'b0001, 1'b0, "rr_release");
    step(20'h01001, 4'b0000, 1'b0, "rr_b");
    check(32'(obs_gnt), 32'h08, "rr_second_in3");

    // Separable loss: input 1 loses VC0, gets VC1 next cycle.
    step(20'h00000, 4'b0000, 1'b1, "rst4");
    step(20'h00033, 4'b0000, 1'b0, "sep_n");
    check(32'(obs_gnt), 32'h01, "sep_n_gnt");
    step(20'h00030, 4'b0000, 1'b0, "sep_n1");
    check(32'(obs_gnt), 32'h02, "sep_n1_gnt");
    check(32'(obs_sel), 32'h00020, "sep_n1_sel");

    // Release and request of the same VC in one cycle.
    step(20'h00000, 4'b0000, 1'b1, "rst5");
    step(20'h10000, 4'b0000, 1'b0, "coll_own");
    step(20'h10000, 4'b0001, 1'b0, "coll_same");
    check(32'(obs_gnt), 32'h00, "coll_no_grant");
    step(20'h10000, 4'b0000, 1'b0, "coll_next");
    check(32'(obs_gnt), 32'h10, "coll_in4");

    // Idle release, fill all VCs, mid-operation reset.
    step(20'h00000, 4'b0000, 1'b1, "rst6");
    step(20'h00000, 4'b1000, 1'b0, "idle_rel");
    check(32'(vc_busy), 32'h0, "idle_rel_busy");
    step(20'h08421, 4'b0000, 1'b0, "fill");
    check(32'(obs_gnt), 32'h0F, "fill_gnt");
    check(32'(vc_busy), 32'hF, "fill_busy");
    step(20'h08421, 4'b0000, 1'b1, "mid_rst");
    check(32'(obs_gnt), 32'h00, "mid_rst_gnt");
    check(32'(vc_busy), 32'h0, "mid_rst_busy");
    step(20'h10001, 4'b0000, 1'b0, "post_rst");
    check(32'(obs_gnt), 32'h01, "post_rst_ptr0");

    // Randomized traffic with sparse releases and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [NI*CN-1:0] rq;
      logic [CN-1:0]    rl;
      rq = '0;
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 2) != 0) rq[i*CN +: CN] = CN'($urandom_range(0, 15));
      rl = CN'($urandom_range(0, 15)) & CN'($urandom_range(0, 15));
      step(rq, rl, ($urandom_range(0, 63) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
